pim_matrix_mem: RTL and testbench

PIM_MATRIX_MEM -- requirements
Module: pim_matrix_mem

---
 rtl/pim_matrix_mem_pkg.sv | 29 ++
 rtl/pim_matrix_mem_if.sv | 50 +++++
 rtl/pim_mem_array.sv | 54 +++++
 rtl/pim_matrix_mem.sv | 148 ++++++++++++++
 tb/tb_pim_matrix_mem.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pim_matrix_mem_pkg.sv
// Shared types and defaults for the PIM matrix memory block.
// State enum, command bundle and element-count helper.
package pim_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 256;
    localparam int DEF_MAX_N = 4;
    localparam int AW_MAX    = 16;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        COLLECT,
        DONE
    } state_e;

    typedef struct packed {
        logic [AW_MAX-1:0] src_a;
        logic [AW_MAX-1:0] src_b;
        logic [AW_MAX-1:0] dst;
        logic [2:0]        n;
    } cmd_t;

    function automatic logic [CNT_W-1:0] elems(input logic [2:0] n);
        return {3'b000, n} * {3'b000, n};
    endfunction

endpackage

// File: rtl/pim_matrix_mem_if.sv
// Command, operand, result and host-preload bundle of pim_matrix_mem.
// master = PIM controller / host side, slave = memory block.
interface pim_matrix_mem_if
    import pim_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = $clog2(DEF_DEPTH)
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [ADDR_W-1:0] cmd_dst;
    logic [2:0]        cmd_n;

    logic              opnd_valid;
    logic              opnd_ready;
    logic [WIDTH-1:0]  opnd_a;
    logic [WIDTH-1:0]  opnd_b;
    logic              opnd_last;

    logic              res_valid;
    logic              res_ready;
    logic [WIDTH-1:0]  res_data;

    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [WIDTH-1:0]  host_wdata;

    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_src_a, cmd_src_b, cmd_dst, cmd_n,
        output opnd_ready, res_valid, res_data,
        output host_we, host_addr, host_wdata,
        input  cmd_ready, opnd_valid, opnd_a, opnd_b, opnd_last,
        input  res_ready, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_src_a, cmd_src_b, cmd_dst, cmd_n,
        input  opnd_ready, res_valid, res_data,
        input  host_we, host_addr, host_wdata,
        output cmd_ready, opnd_valid, opnd_a, opnd_b, opnd_last,
        output res_ready, busy, done, err
    );

endinterface

// File: rtl/pim_mem_array.sv
// Element storage: two registered read ports, one write port.
// PIM_MEM_INIT_EN: reset loads mem[i] = i; otherwise contents survive reset.
module pim_mem_array #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [WIDTH-1:0]  rdata_a_o,
    output logic [WIDTH-1:0]  rdata_b_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_b_q;

`ifdef PIM_MEM_INIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(i);
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            rdata_a_q <= mem_q[raddr_a_i];
            rdata_b_q <= mem_q[raddr_b_i];
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/pim_matrix_mem.sv
// Matrix memory front-end for a PIM controller: streams A/B, collects results.
// Build option PIM_MEM_INIT_EN (in pim_mem_array) preloads mem[i] = i on reset.
module pim_matrix_mem
    import pim_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int MAX_N = DEF_MAX_N
) (
    input logic             clk,
    input logic             rst,
    pim_matrix_mem_if.slave bus_io
);

    localparam int         ADDR_W = $clog2(DEPTH);
    localparam logic [2:0] MAX_N3 = 3'(MAX_N);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;

    logic [CNT_W-1:0]  last_idx;
    logic              cmd_ok;
    logic [ADDR_W-1:0] ra_a, ra_b, waddr;
    logic              we;
    logic [WIDTH-1:0]  wdata, rd_a, rd_b;

    // Base plus offset, wrapped modulo DEPTH.
    function automatic logic [ADDR_W-1:0] wrap(
        input logic [AW_MAX-1:0] base,
        input logic [CNT_W-1:0]  off
    );
        logic [AW_MAX:0] sum;
        sum = {1'b0, base} + (AW_MAX+1)'(off);
        return ADDR_W'(sum % (AW_MAX+1)'(DEPTH));
    endfunction

    assign last_idx = elems(cmd_q.n) - CNT_W'(1);
    assign cmd_ok   = (bus_io.cmd_n != 3'd0) && (bus_io.cmd_n <= MAX_N3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            k_q     <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            k_q     <= k_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        k_d     = k_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        we      = 1'b0;
        waddr   = bus_io.host_addr;
        wdata   = bus_io.host_wdata;
        ra_a    = bus_io.cmd_src_a;
        ra_b    = bus_io.cmd_src_b;
        unique case (state_q)
            IDLE: begin
                we = bus_io.host_we;
                if (bus_io.cmd_valid) begin
                    if (cmd_ok) begin
                        cmd_d = '{
                            src_a: AW_MAX'(bus_io.cmd_src_a),
                            src_b: AW_MAX'(bus_io.cmd_src_b),
                            dst:   AW_MAX'(bus_io.cmd_dst),
                            n:     bus_io.cmd_n
                        };
                        k_d     = '0;
                        vld_d   = 1'b1;
                        state_d = STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (vld_q && bus_io.opnd_ready) begin
                    if (k_q == last_idx) begin
                        vld_d   = 1'b0;
                        k_d     = '0;
                        state_d = COLLECT;
                    end else begin
                        k_d = k_q + CNT_W'(1);
                    end
                end
                // Re-read the held index while stalled so outputs stay put.
                ra_a = wrap(cmd_q.src_a, k_d);
                ra_b = wrap(cmd_q.src_b, k_d);
            end
            COLLECT: begin
                if (bus_io.res_valid) begin
                    we    = 1'b1;
                    waddr = wrap(cmd_q.dst, k_q);
                    wdata = bus_io.res_data;
                    if (k_q == last_idx) begin
                        k_d     = '0;
                        state_d = DONE;
                    end else begin
                        k_d = k_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    pim_mem_array #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .raddr_a_i (ra_a),
        .raddr_b_i (ra_b),
        .rdata_a_o (rd_a),
        .rdata_b_o (rd_b),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata)
    );

    assign bus_io.cmd_ready  = (state_q == IDLE);
    assign bus_io.opnd_valid = vld_q;
    assign bus_io.opnd_a     = vld_q ? rd_a : '0;
    assign bus_io.opnd_b     = vld_q ? rd_b : '0;
    assign bus_io.opnd_last  = vld_q && (k_q == last_idx);
    assign bus_io.res_ready  = (state_q == COLLECT);
    assign bus_io.busy       = (state_q != IDLE);
    assign bus_io.done       = (state_q == DONE);
    assign bus_io.err        = err_q;

endmodule

// File: tb/tb_pim_matrix_mem.sv
// Scoreboard bench for pim_matrix_mem: random jobs against an array model.
// Operand pairs are queued at issue time and popped by an independent monitor.
module tb_pim_matrix_mem;
    import pim_pkg::*;

    localparam int W  = 16;
    localparam int D  = 256;
    localparam int AW = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pim_matrix_mem_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

    pim_matrix_mem #(
        .WIDTH (W),
        .DEPTH (D),
        .MAX_N (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    exp_t         exp_q[$];
    logic [W-1:0] model [D];
    int           n_checks  = 0;
    int           n_fail    = 0;
    int           done_cnt  = 0;
    int           jobs_done = 0;
    int           rdy_mode  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
`ifdef PIM_MEM_INIT_EN
        for (int i = 0; i < D; i++) model[i] = W'(i);
`endif
    endtask

    // Consumer-side ready pattern: 0 = always, 1 = toggle, 2 = random.
    initial begin
        bus.opnd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) bus.opnd_ready = 1'b1;
            else if (rdy_mode == 1) bus.opnd_ready = ~bus.opnd_ready;
            else bus.opnd_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops expected pairs on every operand handshake.
    initial begin
        exp_t         e;
        logic         hold_v;
        logic [W-1:0] hold_a, hold_b;
        logic         hold_l;
        hold_v = 1'b0;
        hold_a = '0;
        hold_b = '0;
        hold_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v)
                    chk("opnd_stable",
                        {bus.opnd_valid, bus.opnd_a, bus.opnd_b, bus.opnd_last},
                        {1'b1, hold_a, hold_b, hold_l});
                if (bus.opnd_valid && bus.opnd_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("opnd_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("opnd_a", bus.opnd_a, e.a);
                        chk("opnd_b", bus.opnd_b, e.b);
                        chk("opnd_last", bus.opnd_last, e.last);
                    end
                end
                hold_v = bus.opnd_valid && !bus.opnd_ready;
                hold_a = bus.opnd_a;
                hold_b = bus.opnd_b;
                hold_l = bus.opnd_last;
                if (bus.done) done_cnt++;
            end
        end
    end

    task automatic host_write(input int addr, input logic [W-1:0] v);
        @(posedge clk);
        #1;
        bus.host_we    = 1'b1;
        bus.host_addr  = AW'(addr);
        bus.host_wdata = v;
        @(posedge clk);
        #1;
        bus.host_we = 1'b0;
        model[addr] = v;
    endtask

    // Returns one step after the handshake edge.
    task automatic issue(input int sa, input int sb, input int d,
                         input int n, input bit hw41);
        logic [W-1:0] v;
        bit           ok;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_src_a = AW'(sa);
        bus.cmd_src_b = AW'(sb);
        bus.cmd_dst   = AW'(d);
        bus.cmd_n     = 3'(n);
        if (hw41) begin
            v              = W'($urandom);
            bus.host_we    = 1'b1;
            bus.host_addr  = AW'(41);
            bus.host_wdata = v;
            model[41]      = v;
        end
        ok = 1'b0;
        for (int t = 0; t < 8 && !ok; t++) begin
            @(negedge clk);
            ok = bus.cmd_ready;
        end
        chk("cmd_accept", ok, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.host_we   = 1'b0;
    endtask

    task automatic err_case(input int n);
        issue(3, 4, 5, n, 1'b0);
        @(negedge clk);
        chk("err_pulse", bus.err, 1);
        chk("err_busy", bus.busy, 0);
        @(negedge clk);
        chk("err_width", bus.err, 0);
        chk("err_idle", {bus.busy, bus.opnd_valid, bus.cmd_ready}, 3'b001);
    endtask

    task automatic run_job(input int sa, input int sb, input int d,
                           input int n, input int mode, input int abort,
                           input bit hw40, input bit hw41);
        int           nn;
        int           t;
        bit           got;
        logic [W-1:0] res [16];
        nn       = n * n;
        rdy_mode = mode;
        for (int k = 0; k < nn; k++) begin
            exp_q.push_back('{a: model[(sa + k) % D], b: model[(sb + k) % D],
                              last: (k == nn - 1)});
            res[k] = W'($urandom);
        end
        issue(sa, sb, d, n, hw41);
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            @(negedge clk);
            got = bus.opnd_valid;
        end
        chk("first_opnd_latency", got, 1);
        if (hw40) begin
            @(posedge clk);
            #1;
            bus.host_we    = 1'b1;
            bus.host_addr  = AW'(40);
            bus.host_wdata = ~model[40];
            @(posedge clk);
            #1;
            bus.host_we = 1'b0;
        end
        // Results are offered before COLLECT; none may be taken early.
        for (int j = 0; j < nn; j++) begin
            if (j == abort) break;
            if (j > 0 && $urandom_range(0, 3) == 0) begin
                bus.res_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.res_valid = 1'b1;
            bus.res_data  = res[j];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.res_ready && t < 200);
            if (!bus.res_ready) begin
                chk("res_timeout", 0, 1);
                bus.res_valid = 1'b0;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                exp_q.delete();
                model_reset();
                return;
            end
            if (j == 0) chk("opnd_before_res", exp_q.size(), 0);
            @(posedge clk);
            #1;
            model[(d + j) % D] = res[j];
        end
        bus.res_valid = 1'b0;
        if (abort >= 0) begin
            rst = 1'b1;
            model_reset();
            @(negedge clk);
            chk("abort_idle",
                {bus.busy, bus.cmd_ready, bus.res_ready, bus.opnd_valid},
                4'b0100);
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk("abort_q_empty", exp_q.size(), 0);
            exp_q.delete();
            return;
        end
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            got = bus.done;
        end
        chk("done_seen", got, 1);
        @(negedge clk);
        chk("done_width", {bus.done, bus.busy, bus.cmd_ready}, 3'b001);
        jobs_done++;
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_src_a  = '0;
        bus.cmd_src_b  = '0;
        bus.cmd_dst    = '0;
        bus.cmd_n      = '0;
        bus.res_valid  = 1'b0;
        bus.res_data   = '0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_opnd_valid", bus.opnd_valid, 0);
        chk("rst_opnd_last", bus.opnd_last, 0);
        chk("rst_res_ready", bus.res_ready, 0);
        chk("rst_status", {bus.busy, bus.done, bus.err}, 3'b000);
        chk("rst_opnd_data", {bus.opnd_a, bus.opnd_b}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < D; i++) host_write(i, W'($urandom));

        run_job(0, 8, 32, 2, 0, -1, 1'b0, 1'b0);
        run_job(100, 120, 140, 3, 1, -1, 1'b0, 1'b0);
        run_job(32, 140, 200, 4, 2, -1, 1'b0, 1'b0);

        err_case(0);
        err_case(5);
        err_case(7);

        run_job(254, 10, 255, 2, 0, -1, 1'b0, 1'b0);
        run_job(252, 255, 253, 4, 2, -1, 1'b0, 1'b0);
        run_job(20, 30, 50, 2, 0, -1, 1'b1, 1'b0);
        run_job(60, 80, 90, 2, 0, -1, 1'b0, 1'b1);
        run_job(40, 44, 100, 2, 1, -1, 1'b0, 1'b0);

        run_job(110, 120, 60, 2, 0, 2, 1'b0, 1'b0);
        run_job(60, 0, 130, 2, 1, -1, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++)
            run_job($urandom_range(0, D - 1), $urandom_range(0, D - 1),
                    $urandom_range(0, D - 1), $urandom_range(1, 4),
                    $urandom_range(0, 2), -1, 1'b0, 1'b0);

        for (int b = 0; b < D; b += 64)
            run_job(b, b + 16, (b + 160) % D, 4, 0, -1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("done_count", done_cnt, jobs_done);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
